// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared encodings and elaboration-time constants for the CORDIC engine
package cordic_pkg;

    localparam logic [1:0] MODE_CIRC = 2'd0;
    localparam logic [1:0] MODE_LIN  = 2'd1;
    localparam logic [1:0] MODE_HYP  = 2'd2;
    localparam logic [1:0] MODE_BAD  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int  IDX_W   = 6;
    localparam real PI_REAL = 3.14159265358979323846;

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int k = 0; k < e; k++) r = r * 2.0;
        end else begin
            for (int k = 0; k < -e; k++) r = r * 0.5;
        end
        return r;
    endfunction

    function automatic int scale(input real v, input int frac);
        real s;
        s = v * pow2(frac);
        return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    endfunction

    // Hyperbolic convergence requires these indices to run twice.
    function automatic bit is_hyp_repeat(input int i);
        return (i == 4) || (i == 13) || (i == 40);
    endfunction

    function automatic int kc_inv_scaled(input int iters, input int frac);
        real p;
        p = 1.0;
        for (int i = 0; i < iters; i++) p = p / $sqrt(1.0 + pow2(-2 * i));
        return scale(p, frac);
    endfunction

    function automatic int kh_inv_scaled(input int iters, input int frac);
        real p;
        p = 1.0;
        for (int i = 1; i < iters; i++) begin
            p = p / $sqrt(1.0 - pow2(-2 * i));
            if (is_hyp_repeat(i)) p = p / $sqrt(1.0 - pow2(-2 * i));
        end
        return scale(p, frac);
    endfunction

    function automatic int pi_scaled(input int frac);
        return scale(PI_REAL, frac);
    endfunction

    function automatic int half_pi_scaled(input int frac);
        return scale(PI_REAL / 2.0, frac);
    endfunction

    function automatic int angle_scaled(input logic [1:0] m, input int i, input int frac);
        real v;
        v = 0.0;
        if (m == MODE_CIRC)
            v = $atan(pow2(-i));
        else if (m == MODE_LIN)
            v = pow2(-i);
        else if (m == MODE_HYP && i > 0)
            v = $atanh(pow2(-i));
        return scale(v, frac);
    endfunction

endpackage

// File: rtl/cordic_angle_lut.sv
// rtl/cordic_angle_lut.sv - per-iteration elementary angle table for all three coordinate systems
module cordic_angle_lut
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 13,
    parameter int ITERATIONS = 16,
    parameter int GUARD      = 2
) (
    input  logic [1:0]                     mode,
    input  logic [IDX_W-1:0]               idx,
    output logic signed [WIDTH+GUARD-1:0]  angle
);

    localparam int IW = WIDTH + GUARD;

    logic signed [IW-1:0] tab_c [ITERATIONS];
    logic signed [IW-1:0] tab_l [ITERATIONS];
    logic signed [IW-1:0] tab_h [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_tab
        assign tab_c[g] = IW'(angle_scaled(MODE_CIRC, g, FRAC));
        assign tab_l[g] = IW'(angle_scaled(MODE_LIN, g, FRAC));
        assign tab_h[g] = IW'(angle_scaled(MODE_HYP, g, FRAC));
    end

    always_comb begin
        angle = '0;
        for (int k = 0; k < ITERATIONS; k++) begin
            if (idx == IDX_W'(k)) begin
                case (mode)
                    MODE_CIRC: angle = tab_c[k];
                    MODE_LIN:  angle = tab_l[k];
                    MODE_HYP:  angle = tab_h[k];
                    default:   angle = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - handshaked multi-mode CORDIC with one shared microrotation datapath
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 13,
    parameter int ITERATIONS = 16,
    parameter int GUARD      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic             is_rotating,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_err,
    output logic             done
);

    localparam int IW = WIDTH + GUARD;

    localparam logic signed [IW-1:0] KC_INV  = IW'(kc_inv_scaled(ITERATIONS, FRAC));
    localparam logic signed [IW-1:0] KH_INV  = IW'(kh_inv_scaled(ITERATIONS, FRAC));
    localparam logic signed [IW-1:0] PI      = IW'(pi_scaled(FRAC));
    localparam logic signed [IW-1:0] HALF_PI = IW'(half_pi_scaled(FRAC));
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (WIDTH - 1)));
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(ITERATIONS - 1);
    localparam logic [IDX_W-1:0]     MAX_SHIFT = IDX_W'(IW - 1);

    logic [1:0]              state;
    logic [1:0]              mode_r;
    logic                    rot_r;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [IW-1:0]    x;
    logic signed [IW-1:0]    y;
    logic signed [IW-1:0]    z;
    logic [IDX_W-1:0]        idx;
    logic                    rep_done;
    logic                    err_r;

    logic signed [IW-1:0]    a_ext;
    logic signed [IW-1:0]    b_ext;
    logic signed [IW-1:0]    abs_a;
    logic signed [IW-1:0]    abs_b;
    logic signed [IW-1:0]    pre_x;
    logic signed [IW-1:0]    pre_y;
    logic signed [IW-1:0]    pre_z;
    logic [IDX_W-1:0]        pre_idx;
    logic                    pre_err;

    logic [IDX_W-1:0]        sh;
    logic signed [IW-1:0]    xs;
    logic signed [IW-1:0]    ys;
    logic signed [IW-1:0]    e;
    logic                    sigma_neg;
    logic signed [IW-1:0]    x_n;
    logic signed [IW-1:0]    y_n;
    logic signed [IW-1:0]    z_n;
    logic                    repeat_now;
    logic signed [IW-1:0]    sel1;
    logic signed [IW-1:0]    sel2;

    function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SAT_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < SAT_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return v[WIDTH-1:0];
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign a_ext    = {{GUARD{a_r[WIDTH-1]}}, a_r};
    assign b_ext    = {{GUARD{b_r[WIDTH-1]}}, b_r};
    assign abs_a    = a_ext[IW-1] ? -a_ext : a_ext;
    assign abs_b    = b_ext[IW-1] ? -b_ext : b_ext;

    cordic_angle_lut #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .ITERATIONS (ITERATIONS),
        .GUARD      (GUARD)
    ) u_lut (
        .mode  (mode_r),
        .idx   (idx),
        .angle (e)
    );

    // Circular rotation folds the outer quadrants onto +/-pi/2 by negating x.
    always_comb begin
        pre_x   = '0;
        pre_y   = '0;
        pre_z   = '0;
        pre_idx = '0;
        pre_err = 1'b0;
        case (mode_r)
            MODE_CIRC: begin
                if (rot_r) begin
                    pre_x = KC_INV;
                    pre_z = a_ext;
                    if (a_ext > HALF_PI) begin
                        pre_x = -KC_INV;
                        pre_z = a_ext - PI;
                    end else if (a_ext < -HALF_PI) begin
                        pre_x = -KC_INV;
                        pre_z = a_ext + PI;
                    end
                end else if (a_ext < 0) begin
                    pre_x = -a_ext;
                    pre_y = -b_ext;
                    pre_z = b_ext[IW-1] ? -PI : PI;
                end else begin
                    pre_x = a_ext;
                    pre_y = b_ext;
                end
            end
            MODE_LIN: begin
                pre_x = a_ext;
                if (rot_r)
                    pre_z = b_ext;
                else
                    pre_y = b_ext;
            end
            MODE_HYP: begin
                pre_idx = IDX_W'(1);
                if (rot_r) begin
                    pre_x = KH_INV;
                    pre_z = a_ext;
                end else begin
                    pre_x   = a_ext;
                    pre_y   = b_ext;
                    pre_err = (abs_b >= abs_a) || (a_ext <= 0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sh         = (idx > MAX_SHIFT) ? MAX_SHIFT : idx;
        xs         = x >>> sh;
        ys         = y >>> sh;
        sigma_neg  = rot_r ? z[IW-1] : ~y[IW-1];
        y_n        = sigma_neg ? (y - xs) : (y + xs);
        z_n        = sigma_neg ? (z + e) : (z - e);
        repeat_now = (mode_r == MODE_HYP) && !rep_done && is_hyp_repeat(int'(idx));
        case (mode_r)
            MODE_CIRC: x_n = sigma_neg ? (x + ys) : (x - ys);
            MODE_HYP:  x_n = sigma_neg ? (x - ys) : (x + ys);
            default:   x_n = x;
        endcase
    end

    always_comb begin
        sel1 = '0;
        sel2 = '0;
        case (mode_r)
            MODE_CIRC, MODE_HYP: begin
                sel1 = x;
                sel2 = rot_r ? y : z;
            end
            MODE_LIN: begin
                sel1 = rot_r ? y : z;
                sel2 = rot_r ? z : y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_r    <= '0;
            rot_r     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            idx       <= '0;
            rep_done  <= 1'b0;
            err_r     <= 1'b0;
            out_valid <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mode_r <= mode;
                        rot_r  <= is_rotating;
                        a_r    <= a;
                        b_r    <= b;
                        err_r  <= (mode == MODE_BAD);
                        state  <= (mode == MODE_BAD) ? ST_DONE : ST_PRE;
                    end
                end
                ST_PRE: begin
                    x        <= pre_x;
                    y        <= pre_y;
                    z        <= pre_z;
                    idx      <= pre_idx;
                    rep_done <= 1'b0;
                    err_r    <= pre_err;
                    state    <= ST_ITER;
                end
                ST_ITER: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    if (repeat_now) begin
                        rep_done <= 1'b1;
                    end else begin
                        rep_done <= 1'b0;
                        idx      <= idx + 1'b1;
                        if (idx == LAST_IDX)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes; afterwards hold until consumed.
                    if (!out_valid) begin
                        out1      <= sat(sel1);
                        out2      <= sat(sel2);
                        out_err   <= err_r;
                        out_valid <= 1'b1;
                        done      <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - randomized self-checking bench for cordic_engine against a real-math model
module tb_cordic_engine;

    localparam int  WIDTH      = 16;
    localparam int  FRAC       = 13;
    localparam int  ITERATIONS = 16;
    localparam int  GUARD      = 2;
    localparam real SCALE      = 8192.0;
    localparam int  TOL_DIR    = 3;
    localparam int  TOL_RND    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic             is_rotating;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic             out_err;
    logic             done;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  done_cnt = 0;
    real kc_g;
    real kh_g;

    cordic_engine #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .ITERATIONS (ITERATIONS),
        .GUARD      (GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .is_rotating (is_rotating),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out1        (out1),
        .out2        (out2),
        .out_err     (out_err),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        int diff;
        diff = obs - exp;
        n_tests++;
        if (diff > tol || diff < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rr(input int n);
        return int'($urandom_range(0, 2 * n)) - n;
    endfunction

    // Iteration count from the index range plus the hyperbolic double steps.
    function automatic int exp_lat(input int m);
        int i0;
        int reps;
        int rp [3];
        if (m == 3) return 1;
        rp   = '{4, 13, 40};
        i0   = (m == 2) ? 1 : 0;
        reps = 0;
        if (m == 2)
            for (int k = 0; k < 3; k++)
                if (rp[k] >= i0 && rp[k] < ITERATIONS) reps++;
        return 2 + ITERATIONS - i0 + reps;
    endfunction

    task automatic model(input int m, input bit rot, input int av, input int bv,
                         output int e1, output int e2, output int eerr, output bit has_vals);
        real ar;
        real br;
        ar       = real'(av) / SCALE;
        br       = real'(bv) / SCALE;
        e1       = 0;
        e2       = 0;
        eerr     = 0;
        has_vals = 1'b1;
        case (m)
            0: begin
                if (rot) begin
                    e1 = rnd($cos(ar) * SCALE);
                    e2 = rnd($sin(ar) * SCALE);
                end else begin
                    e1 = sat16(rnd(kc_g * $sqrt(ar * ar + br * br) * SCALE));
                    e2 = rnd($atan2(br, ar) * SCALE);
                end
            end
            1: begin
                if (rot) begin
                    e1 = sat16(rnd(ar * br * SCALE));
                    e2 = 0;
                end else begin
                    e1 = rnd(br / ar * SCALE);
                    e2 = 0;
                end
            end
            2: begin
                if (rot) begin
                    e1 = rnd($cosh(ar) * SCALE);
                    e2 = rnd($sinh(ar) * SCALE);
                end else begin
                    eerr = (iabs(bv) >= iabs(av) || av <= 0) ? 1 : 0;
                    if (eerr != 0) begin
                        has_vals = 1'b0;
                    end else begin
                        e1 = rnd(kh_g * $sqrt(ar * ar - br * br) * SCALE);
                        e2 = rnd(0.5 * $ln((1.0 + br / ar) / (1.0 - br / ar)) * SCALE);
                    end
                end
            end
            default: eerr = 1;
        endcase
    endtask

    task automatic do_case(input string tag, input int m, input bit rot, input int av, input int bv,
                           input int tol, input int hold, input bit poke);
        int e1, e2, eerr, lat, d0;
        bit has_vals;
        bit busy_ok;
        model(m, rot, av, bv, e1, e2, eerr, has_vals);
        @(negedge clk);
        mode        = m[1:0];
        is_rotating = rot;
        a           = av[15:0];
        b           = bv[15:0];
        in_valid    = 1'b1;
        d0          = done_cnt;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 64 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        check({tag, ".lat"}, lat, exp_lat(m));
        check({tag, ".err"}, int'(out_err), eerr);
        if (has_vals) begin
            check({tag, ".out1"}, int'($signed(out1)), e1, tol);
            check({tag, ".out2"}, int'($signed(out2)), e2, tol);
        end
        if (hold > 0) begin
            busy_ok = 1'b1;
            for (int k = 0; k < hold; k++) begin
                if (poke) begin
                    mode     = 2'd1;
                    a        = 16'h1234;
                    b        = 16'h0fff;
                    in_valid = 1'b1;
                end
                @(posedge clk);
                #1;
                if (!out_valid || in_ready) busy_ok = 1'b0;
            end
            in_valid = 1'b0;
            check({tag, ".held_busy"}, int'(busy_ok), 1);
            check({tag, ".held_err"}, int'(out_err), eerr);
            if (has_vals) begin
                check({tag, ".held1"}, int'($signed(out1)), e1, tol);
                check({tag, ".held2"}, int'($signed(out2)), e2, tol);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ".released"}, int'(out_valid), 0);
        check({tag, ".in_ready"}, int'(in_ready), 1);
        check({tag, ".done_pulses"}, done_cnt - d0, 1);
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, ".not_queued"}, int'(in_ready && !out_valid), 1);
        end
    endtask

    task automatic random_case(input int t);
        int  m;
        bit  rot;
        int  av;
        int  bv;
        int  hold;
        m    = int'($urandom_range(0, 2));
        rot  = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(0, 3));
        av   = 0;
        bv   = 0;
        case (m)
            0: begin
                if (rot) begin
                    av = rr(25735);
                    bv = rr(30000);
                end else begin
                    do begin
                        av = rr(8000);
                        bv = rr(8000);
                    end while (iabs(av) + iabs(bv) < 1500);
                end
            end
            1: begin
                if (rot) begin
                    av = rr(16000);
                    bv = rr(12000);
                end else begin
                    av = 4000 + int'($urandom_range(0, 12000));
                    bv = rr(av);
                end
            end
            default: begin
                if (rot) begin
                    av = rr(7000);
                end else begin
                    av = 4000 + int'($urandom_range(0, 8000));
                    bv = rr(av * 3 / 4);
                end
            end
        endcase
        do_case($sformatf("rnd%0d_m%0d_r%0d", t, m, rot), m, rot, av, bv, TOL_RND, hold, 1'b0);
    endtask

    task automatic reset_mid_iter();
        @(negedge clk);
        mode        = 2'd0;
        is_rotating = 1'b1;
        a           = 16'd4289;
        b           = 16'd0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("rst_mid.busy", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.out_valid", int'(out_valid), 0);
        check("rst_mid.in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("rst_mid.lost", int'(out_valid), 0);
    endtask

    task automatic compute_gains();
        kc_g = 1.0;
        kh_g = 1.0;
        for (int i = 0; i < ITERATIONS; i++) kc_g = kc_g * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        for (int i = 1; i < ITERATIONS; i++) begin
            kh_g = kh_g * $sqrt(1.0 - $pow(2.0, -2.0 * i));
            if (i == 4 || i == 13) kh_g = kh_g * $sqrt(1.0 - $pow(2.0, -2.0 * i));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        mode        = 2'd0;
        is_rotating = 1'b0;
        a           = '0;
        b           = '0;
        compute_gains();

        #12;
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.out1", int'(out1), 0);
        check("rst.out2", int'(out2), 0);
        check("rst.out_err", int'(out_err), 0);
        check("rst.done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_case("circ_rot_pi6",    0, 1'b1,  4289,     0, TOL_DIR, 0, 1'b0);
        do_case("circ_rot_3pi4",   0, 1'b1, 19302,     0, TOL_DIR, 0, 1'b0);
        do_case("circ_rot_m3pi4",  0, 1'b1, -19302,    0, TOL_DIR, 0, 1'b0);
        do_case("circ_vec_neg_a",  0, 1'b0, -8192,  8192, TOL_DIR, 0, 1'b0);
        do_case("circ_vec_diag",   0, 1'b0,  8192,  8192, TOL_DIR, 0, 1'b0);
        do_case("lin_rot",         1, 1'b1, 12288,  4096, TOL_DIR, 0, 1'b0);
        do_case("lin_vec",         1, 1'b0,  8192,  4096, TOL_DIR, 0, 1'b0);
        do_case("lin_rot_sat_pos", 1, 1'b1, 32767, 16000, TOL_DIR, 0, 1'b0);
        do_case("lin_rot_sat_neg", 1, 1'b1, -32768, 16000, TOL_DIR, 0, 1'b0);
        do_case("hyp_rot",         2, 1'b1,  4096,     0, TOL_DIR, 0, 1'b0);
        do_case("hyp_vec_ok",      2, 1'b0,  8192,  4096, TOL_RND, 0, 1'b0);
        do_case("hyp_vec_err",     2, 1'b0,  4096,  8192, TOL_DIR, 0, 1'b0);
        do_case("hyp_vec_neg_a",   2, 1'b0, -8192,  1000, TOL_DIR, 0, 1'b0);
        do_case("bad_mode",        3, 1'b1,  1234,  5678, 0,       0, 1'b0);
        do_case("backpressure",    0, 1'b1,  4289,     0, TOL_DIR, 5, 1'b1);

        reset_mid_iter();
        do_case("after_reset",     0, 1'b1, -4289,     0, TOL_DIR, 0, 1'b0);

        for (int t = 0; t < 24; t++) random_case(t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
